uart_ascii_cmd_decoder: RTL and testbench

Byte-level stage directly downstream of the UART receiver inside `TOP`. It consumes each received 8-bit character (8N1, 9600 baud at 100 MHz) and decodes ASCII hex digits into a 4-bit nibble for display (`oDEC`). It accumulates consecutive digits into a multi-nibble value and emits a `{value, command}` pair when a command letter or line terminator arrives. Malformed input and stalled sequences are flagged rather than silently merged into the next command.

---
 rtl/uart_ascii_cmd_decoder.sv | 93 +++++++++
 tb/tb_uart_ascii_cmd_decoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ascii_cmd_decoder.sv
// uart_ascii_cmd_decoder: turns received ASCII bytes into hex nibbles and {value, command} pairs.
// Optional idle-gap abort of partial sequences when ASCII_CMD_TIMEOUT_EN is defined.
module uart_ascii_cmd_decoder #(
  parameter int DIGITS         = 4,
  parameter int TIMEOUT_CYCLES = 208333
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [3:0]            oDEC,
  output logic                  dec_valid,
  output logic [DIGITS*4-1:0]   value,
  output logic [7:0]            cmd,
  output logic                  cmd_valid,
  output logic                  overflow,
  output logic                  err
);
  localparam int W  = DIGITS * 4;
  localparam int CW = $clog2(DIGITS + 1);
  typedef enum logic {IDLE, ACCUM} state_t;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 262144) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 18-bit gap counter");
  end
  state_t          r_state;
  logic [W-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic            w_is_hex;
  logic            w_is_cmd;
  logic            w_is_eol;
  logic [3:0]      w_nib;
  logic            w_full;
  always_comb begin
    w_is_hex = (rx_data >= 8'h30 && rx_data <= 8'h39) ||
               (rx_data >= 8'h41 && rx_data <= 8'h46) ||
               (rx_data >= 8'h61 && rx_data <= 8'h66);
    w_is_cmd = (rx_data >= 8'h47 && rx_data <= 8'h5A) ||
               (rx_data >= 8'h67 && rx_data <= 8'h7A);
    w_is_eol = rx_data == 8'h0D || rx_data == 8'h0A;
    w_nib    = rx_data <= 8'h39 ? rx_data[3:0] : rx_data[3:0] + 4'd9;
    w_full   = r_cnt == CW'(DIGITS);
  end
`ifdef ASCII_CMD_TIMEOUT_EN
  logic [17:0] r_gap;
  logic        w_tmo;
  assign w_tmo = r_state == ACCUM && !rx_valid && r_gap == 18'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_gap <= '0;
    else        r_gap <= (rx_valid || r_state == IDLE || w_tmo) ? '0 : r_gap + 18'd1;
  end
`else
  logic w_tmo;
  assign w_tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      oDEC      <= '0;
      dec_valid <= 1'b0;
      value     <= '0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      dec_valid <= 1'b0;
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      if (rx_valid && w_is_hex) begin
        // acc is always zero in IDLE, so one shift-in covers both states
        r_acc     <= (r_acc << 4) | W'(w_nib);
        r_cnt     <= w_full ? r_cnt : r_cnt + CW'(1);
        overflow  <= overflow | w_full;
        r_state   <= ACCUM;
        oDEC      <= w_nib;
        dec_valid <= 1'b1;
      end else if (rx_valid || w_tmo) begin
        if (rx_valid && (w_is_cmd || (w_is_eol && r_state == ACCUM))) begin
          value     <= r_acc;
          cmd       <= w_is_cmd ? rx_data : 8'h00;
          cmd_valid <= 1'b1;
        end
        err      <= w_tmo || !(w_is_cmd || w_is_eol);
        r_acc    <= '0;
        r_cnt    <= '0;
        overflow <= 1'b0;
        r_state  <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_uart_ascii_cmd_decoder.sv
// tb_uart_ascii_cmd_decoder: directed scenarios plus randomized bytes against a per-cycle reference model.
module tb_uart_ascii_cmd_decoder;
  localparam int D = 4;
  localparam int W = D * 4;
  localparam int T = 40;
  logic clk = 0, reset = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic [3:0] oDEC;
  logic dec_valid, cmd_valid, overflow, err;
  logic [W-1:0] value;
  logic [7:0] cmd;
  int total = 0, passed = 0;
  uart_ascii_cmd_decoder #(.DIGITS(D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .oDEC(oDEC), .dec_valid(dec_valid), .value(value), .cmd(cmd),
    .cmd_valid(cmd_valid), .overflow(overflow), .err(err)
  );
  always #5 clk = ~clk;
  // reference model: digit list kept as count plus running base-16 value modulo 16^D
  int m_cnt = 0, m_idle = 0;
  longint m_acc = 0;
  logic [3:0] e_odec = 0;
  logic e_dv = 0, e_cv = 0, e_ovf = 0, e_err = 0;
  logic [W-1:0] e_val = 0;
  logic [7:0] e_cmd = 0;
  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction
  function automatic bit is_cmd(input logic [7:0] b);
    return (b >= "G" && b <= "Z") || (b >= "g" && b <= "z");
  endfunction
  task automatic m_clear();
    m_acc = 0; m_cnt = 0; m_idle = 0; e_ovf = 0;
  endtask
  always @(posedge clk) begin
    int h;
    if (!reset) begin
      m_clear();
      e_odec = 0; e_dv = 0; e_cv = 0; e_err = 0; e_val = 0; e_cmd = 0;
    end else begin
      e_dv = 0; e_cv = 0; e_err = 0;
      if (rx_valid) begin
        m_idle = 0;
        h = hexval(rx_data);
        if (h >= 0) begin
          e_odec = h[3:0]; e_dv = 1;
          m_acc = (m_acc * 16 + h) % (64'd1 << W);
          m_cnt++;
          if (m_cnt > D) e_ovf = 1;
        end else if (is_cmd(rx_data)) begin
          e_cv = 1; e_val = m_acc[W-1:0]; e_cmd = rx_data; m_clear();
        end else if (rx_data == 8'h0D || rx_data == 8'h0A) begin
          if (m_cnt > 0) begin e_cv = 1; e_val = m_acc[W-1:0]; e_cmd = 0; end
          m_clear();
        end else begin
          e_err = 1; m_clear();
        end
      end
`ifdef ASCII_CMD_TIMEOUT_EN
      else if (m_cnt > 0) begin
        m_idle++;
        if (m_idle == T) begin e_err = 1; m_clear(); end
      end
`endif
    end
  end
  always @(negedge clk) begin
    if (reset) begin
      total++;
      if ({oDEC, dec_valid, value, cmd, cmd_valid, overflow, err} !==
          {e_odec, e_dv, e_val, e_cmd, e_cv, e_ovf, e_err})
        $display("FAIL model t=%0t got oDEC=%h dv=%b val=%h cmd=%h cv=%b ovf=%b err=%b want oDEC=%h dv=%b val=%h cmd=%h cv=%b ovf=%b err=%b",
                 $time, oDEC, dec_valid, value, cmd, cmd_valid, overflow, err,
                 e_odec, e_dv, e_val, e_cmd, e_cv, e_ovf, e_err);
      else passed++;
    end
  end
  task automatic put(input logic [7:0] b);
    rx_data = b; rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({oDEC, dec_valid, value, cmd, cmd_valid, overflow, err} !== '0)
      $display("FAIL reset_values got %h want 0", {oDEC, dec_valid, value, cmd, cmd_valid, overflow, err});
    else passed++;
    reset = 1;
    @(negedge clk);
  endtask
  task automatic test_basic();
    logic [7:0] s [3] = '{"2", "1", "3"};
    logic [3:0] n [3] = '{4'h2, 4'h1, 4'h3};
    int errs = 0;
    for (int i = 0; i < 3; i++) begin
      put(s[i]);
      total++;
      if ({dec_valid, oDEC} !== {1'b1, n[i]}) $display("FAIL basic_digit%0d got dv=%b oDEC=%h want dv=1 oDEC=%h", i, dec_valid, oDEC, n[i]);
      else passed++;
      errs += err;
      idle(5);
    end
    put("M");
    total++;
    if ({cmd_valid, value, cmd, err} !== {1'b1, 16'h0213, 8'h4D, 1'b0} || errs != 0)
      $display("FAIL basic_emit got cv=%b val=%h cmd=%h err=%b errs=%0d want cv=1 val=0213 cmd=4d err=0 errs=0", cmd_valid, value, cmd, err, errs);
    else passed++;
    idle(2);
  endtask
  task automatic test_eol();
    put("5");
    put("F");
    total++;
    if ({dec_valid, oDEC} !== {1'b1, 4'hF}) $display("FAIL eol_digit got dv=%b oDEC=%h want dv=1 oDEC=f", dec_valid, oDEC);
    else passed++;
    put(8'h0A);
    total++;
    if ({cmd_valid, value, cmd} !== {1'b1, 16'h005F, 8'h00}) $display("FAIL eol_emit got cv=%b val=%h cmd=%h want cv=1 val=005f cmd=00", cmd_valid, value, cmd);
    else passed++;
    idle(2);
  endtask
  task automatic test_back_to_back();
    string s = "12345";
    int dv = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        total++;
        if (overflow !== 1'b0) $display("FAIL b2b_ovf_before got %b want 0", overflow);
        else passed++;
      end
      put(s[i]);
      dv += dec_valid;
    end
    total++;
    if (overflow !== 1'b1 || dv != 5) $display("FAIL b2b_overflow got ovf=%b pulses=%0d want ovf=1 pulses=5", overflow, dv);
    else passed++;
    put("X");
    total++;
    if ({cmd_valid, value, cmd, overflow} !== {1'b1, 16'h2345, 8'h58, 1'b0})
      $display("FAIL b2b_emit got cv=%b val=%h cmd=%h ovf=%b want cv=1 val=2345 cmd=58 ovf=0", cmd_valid, value, cmd, overflow);
    else passed++;
    idle(2);
  endtask
  task automatic test_illegal();
    put("7");
    put(8'h2C);
    total++;
    if ({err, cmd_valid} !== 2'b10) $display("FAIL illegal_err got err=%b cv=%b want err=1 cv=0", err, cmd_valid);
    else passed++;
    put("Q");
    total++;
    if ({cmd_valid, value, cmd, err} !== {1'b1, 16'h0000, 8'h51, 1'b0})
      $display("FAIL illegal_emit got cv=%b val=%h cmd=%h err=%b want cv=1 val=0000 cmd=51 err=0", cmd_valid, value, cmd, err);
    else passed++;
    idle(2);
  endtask
  task automatic test_timeout();
    int first = 0;
    logic [W-1:0] want;
    put("9");
    for (int i = 1; i <= 3 * T; i++) begin
      @(negedge clk);
      if (err && first == 0) first = i;
    end
`ifdef ASCII_CMD_TIMEOUT_EN
    want = 0;
    total++;
    if (first != T) $display("FAIL timeout_cycle got %0d want %0d", first, T);
    else passed++;
`else
    want = 16'h0009;
    total++;
    if (first != 0) $display("FAIL timeout_none got err at %0d want never", first);
    else passed++;
`endif
    put("Z");
    total++;
    if ({cmd_valid, value, cmd} !== {1'b1, want, 8'h5A}) $display("FAIL timeout_emit got cv=%b val=%h cmd=%h want cv=1 val=%h cmd=5a", cmd_valid, value, cmd, want);
    else passed++;
    idle(2);
  endtask
  task automatic test_reset_mid();
    put("4");
    @(posedge clk);
    #3 reset = 0;
    #1;
    total++;
    if ({oDEC, dec_valid, value, cmd, cmd_valid, overflow, err} !== '0)
      $display("FAIL reset_mid got %h want 0", {oDEC, dec_valid, value, cmd, cmd_valid, overflow, err});
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if ({cmd_valid, err} !== 2'b00) $display("FAIL reset_mid_pulse got cv=%b err=%b want 0 0", cmd_valid, err);
    else passed++;
    reset = 1;
    put("M");
    total++;
    if ({cmd_valid, value, cmd} !== {1'b1, 16'h0000, 8'h4D}) $display("FAIL reset_mid_emit got cv=%b val=%h cmd=%h want cv=1 val=0000 cmd=4d", cmd_valid, value, cmd);
    else passed++;
    idle(2);
  endtask
  task automatic test_random();
    string hs = "0123456789ABCDEFabcdef";
    logic [7:0] b;
    int c;
    for (int i = 0; i < 1500; i++) begin
      c = $urandom_range(0, 9);
      if (c <= 4) b = hs[$urandom_range(0, 21)];
      else if (c <= 6) b = ($urandom_range(0, 1) ? 8'h47 : 8'h67) + 8'($urandom_range(0, 19));
      else if (c == 7) b = $urandom_range(0, 1) ? 8'h0D : 8'h0A;
      else b = 8'($urandom);
      put(b);
      if ($urandom_range(0, 40) == 0) idle(T - 3 + $urandom_range(0, 4));
      else idle($urandom_range(0, 3));
    end
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_eol();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
